// File: rtl/pong_game_sequencer_if.sv
// Frame-level signals between the sync generator, physics/render logic and
// the pong game-flow sequencer.
interface pong_game_sequencer_if;
    logic       iVS;
    logic       start_in;
    logic       miss_l;
    logic       miss_r;
    logic       frame_tick;
    logic [2:0] state_o;
    logic       physics_en;
    logic       ball_reset;
    logic       serve_dir;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       game_over;

    modport master (
        output iVS, start_in, miss_l, miss_r,
        input  frame_tick, state_o, physics_en, ball_reset, serve_dir,
               score_l, score_r, game_over
    );

    modport slave (
        input  iVS, start_in, miss_l, miss_r,
        output frame_tick, state_o, physics_en, ball_reset, serve_dir,
               score_l, score_r, game_over
    );
endinterface

// File: rtl/pong_game_sequencer.sv
// Pong match flow: vsync edge to frame tick, serve/play/point/over sequencing,
// score keeping. Everything advances only on the frame tick.
//
// state | meaning
// IDLE  | attract, waiting for start
// SERVE | countdown before play, ball centred
// PLAY  | physics running, watching for misses
// POINT | pause after a miss
// OVER  | match won, scores frozen until re-armed start
module pong_game_sequencer #(
    parameter int WIN_SCORE    = 5,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30
) (
    input  logic                  iVGA_CLK,
    input  logic                  iRST_n,
    pong_game_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [7:0] SERVE_LD = 8'(SERVE_FRAMES);
    localparam logic [7:0] POINT_LD = 8'(POINT_FRAMES);
    localparam logic [3:0] WIN_LD   = 4'(WIN_SCORE);

    state_t     r_state;
    logic       r_vs_q;
    logic       r_frame_tick;
    logic       r_physics_en;
    logic       r_ball_reset;
    logic       r_serve_dir;
    logic [3:0] r_score_l;
    logic [3:0] r_score_r;
    logic       r_game_over;
    logic [7:0] r_cnt;
    logic       r_armed;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state      <= S_IDLE;
            r_vs_q       <= 1'b1;
            r_frame_tick <= 1'b0;
            r_physics_en <= 1'b0;
            r_ball_reset <= 1'b0;
            r_serve_dir  <= 1'b1;
            r_score_l    <= 4'd0;
            r_score_r    <= 4'd0;
            r_game_over  <= 1'b0;
            r_cnt        <= 8'd0;
            r_armed      <= 1'b0;
        end else begin
            r_vs_q       <= bus.iVS;
            r_frame_tick <= bus.iVS & ~r_vs_q;
            r_ball_reset <= 1'b0;
            if (r_frame_tick) begin
                if (!bus.start_in) r_armed <= 1'b1;
                case (r_state)
                    S_IDLE: begin
                        if (bus.start_in) begin
                            r_score_l    <= 4'd0;
                            r_score_r    <= 4'd0;
                            r_serve_dir  <= 1'b1;
                            r_cnt        <= SERVE_LD;
                            r_ball_reset <= 1'b1;
                            r_state      <= S_SERVE;
                        end
                    end
                    S_SERVE: begin
                        r_cnt <= r_cnt - 8'd1;
                        if (r_cnt == 8'd1) begin
                            r_state      <= S_PLAY;
                            r_physics_en <= 1'b1;
                        end
                    end
                    S_PLAY: begin
                        if (bus.miss_l || bus.miss_r) begin
                            // Simultaneous misses are a wash: no point, serve unchanged.
                            if (bus.miss_l && !bus.miss_r) begin
                                if (r_score_r != 4'd15) r_score_r <= r_score_r + 4'd1;
                                r_serve_dir <= 1'b0;
                            end else if (bus.miss_r && !bus.miss_l) begin
                                if (r_score_l != 4'd15) r_score_l <= r_score_l + 4'd1;
                                r_serve_dir <= 1'b1;
                            end
                            r_cnt        <= POINT_LD;
                            r_state      <= S_POINT;
                            r_physics_en <= 1'b0;
                        end
                    end
                    S_POINT: begin
                        r_cnt <= r_cnt - 8'd1;
                        if (r_cnt == 8'd1) begin
                            if (r_score_l >= WIN_LD || r_score_r >= WIN_LD) begin
                                r_state     <= S_OVER;
                                r_game_over <= 1'b1;
                                r_armed     <= 1'b0;
                            end else begin
                                r_ball_reset <= 1'b1;
                                r_cnt        <= SERVE_LD;
                                r_state      <= S_SERVE;
                            end
                        end
                    end
                    S_OVER: begin
                        // Armed only after a tick with start released, so a held button can't restart.
                        if (bus.start_in && r_armed) begin
                            r_state     <= S_IDLE;
                            r_game_over <= 1'b0;
                        end
                    end
                    default: begin
                        r_state      <= S_IDLE;
                        r_physics_en <= 1'b0;
                        r_game_over  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.frame_tick = r_frame_tick;
    assign bus.state_o    = r_state;
    assign bus.physics_en = r_physics_en;
    assign bus.ball_reset = r_ball_reset;
    assign bus.serve_dir  = r_serve_dir;
    assign bus.score_l    = r_score_l;
    assign bus.score_r    = r_score_r;
    assign bus.game_over  = r_game_over;
endmodule

// File: tb/tb_pong_game_sequencer.sv
// Bench for pong_game_sequencer: directed vector table, corner sequences,
// and random frames checked against a match-level reference model.
module tb_pong_game_sequencer;
    localparam int WIN = 5;
    localparam int SF  = 3;
    localparam int PF  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pong_game_sequencer_if bus();

    pong_game_sequencer #(
        .WIN_SCORE(WIN), .SERVE_FRAMES(SF), .POINT_FRAMES(PF)
    ) dut (
        .iVGA_CLK(clk),
        .iRST_n(rst_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Match-level model: phase name, scores, serve side, ticks spent in phase.
    int m_state, m_sl, m_sr, m_dir, m_armed, m_ticks, m_br;

    typedef struct {
        int s, ml, mr;
        int st, sl, sr, dir, br;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_sl = 0; m_sr = 0; m_dir = 1;
        m_armed = 0; m_ticks = 0; m_br = 0;
    endtask

    task automatic model_step(input int s, input int ml, input int mr);
        int was_armed;
        was_armed = m_armed;
        m_br = 0;
        if (s == 0) m_armed = 1;
        if (m_state == 0) begin
            if (s != 0) begin
                m_sl = 0; m_sr = 0; m_dir = 1;
                m_state = 1; m_ticks = 0; m_br = 1;
            end
        end else if (m_state == 1) begin
            m_ticks++;
            if (m_ticks == SF) m_state = 2;
        end else if (m_state == 2) begin
            if (ml != 0 || mr != 0) begin
                if (ml != 0 && mr == 0) begin
                    m_sr = (m_sr < 15) ? m_sr + 1 : 15;
                    m_dir = 0;
                end else if (mr != 0 && ml == 0) begin
                    m_sl = (m_sl < 15) ? m_sl + 1 : 15;
                    m_dir = 1;
                end
                m_state = 3; m_ticks = 0;
            end
        end else if (m_state == 3) begin
            m_ticks++;
            if (m_ticks == PF) begin
                if (m_sl >= WIN || m_sr >= WIN) begin
                    m_state = 4; m_armed = 0;
                end else begin
                    m_state = 1; m_ticks = 0; m_br = 1;
                end
            end
        end else if (m_state == 4) begin
            if (s != 0 && was_armed != 0) m_state = 0;
        end
    endtask

    task automatic check_model();
        chk("state", int'(bus.state_o), m_state);
        chk("score_l", int'(bus.score_l), m_sl);
        chk("score_r", int'(bus.score_r), m_sr);
        chk("serve_dir", int'(bus.serve_dir), m_dir);
        chk("physics_en", int'(bus.physics_en), (m_state == 2) ? 1 : 0);
        chk("game_over", int'(bus.game_over), (m_state == 4) ? 1 : 0);
        chk("ball_reset", int'(bus.ball_reset), m_br);
    endtask

    // One vsync frame: iVS low for lo cycles, then high; check on the cycle after the tick.
    task automatic do_frame(input int s, input int ml, input int mr, input int lo);
        int found;
        int k;
        @(posedge clk); #1;
        bus.iVS = 1'b0;
        bus.start_in = 1'(s);
        bus.miss_l = 1'(ml);
        bus.miss_r = 1'(mr);
        repeat (lo) @(posedge clk);
        #1 bus.iVS = 1'b1;
        found = 0;
        k = 0;
        while (found == 0 && k < 4) begin
            @(negedge clk);
            if (bus.frame_tick) found = 1;
            k++;
        end
        chk("tick_seen", found, 1);
        if (found != 0) begin
            @(negedge clk);
            model_step(s, ml, mr);
            chk("tick_width", int'(bus.frame_tick), 0);
            check_model();
            @(negedge clk);
            chk("ball_reset_width", int'(bus.ball_reset), 0);
        end
    endtask

    task automatic add(input int s, input int ml, input int mr, input int st,
                       input int sl, input int sr, input int dir, input int br);
        vec_t v;
        v.s = s; v.ml = ml; v.mr = mr;
        v.st = st; v.sl = sl; v.sr = sr; v.dir = dir; v.br = br;
        tbl.push_back(v);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"}, int'(bus.state_o), 0);
        chk({tag, "_tick"}, int'(bus.frame_tick), 0);
        chk({tag, "_phys"}, int'(bus.physics_en), 0);
        chk({tag, "_br"}, int'(bus.ball_reset), 0);
        chk({tag, "_dir"}, int'(bus.serve_dir), 1);
        chk({tag, "_sl"}, int'(bus.score_l), 0);
        chk({tag, "_sr"}, int'(bus.score_r), 0);
        chk({tag, "_over"}, int'(bus.game_over), 0);
    endtask

    initial begin
        int s, ml, mr, guard;
        bus.iVS = 1'b0; bus.start_in = 1'b0; bus.miss_l = 1'b0; bus.miss_r = 1'b0;
        model_reset();

        // attract x3, start, serve, points left / right / both
        add(0,0,0, 0,0,0,1,0); add(0,0,0, 0,0,0,1,0); add(0,0,0, 0,0,0,1,0);
        add(1,0,0, 1,0,0,1,1); add(0,0,0, 1,0,0,1,0); add(0,0,0, 1,0,0,1,0);
        add(0,0,0, 2,0,0,1,0);
        add(0,0,1, 3,1,0,1,0); add(0,0,0, 3,1,0,1,0); add(0,0,0, 1,1,0,1,1);
        add(0,0,0, 1,1,0,1,0); add(0,0,0, 1,1,0,1,0); add(0,0,0, 2,1,0,1,0);
        add(0,1,0, 3,1,1,0,0); add(0,0,0, 3,1,1,0,0); add(0,0,0, 1,1,1,0,1);
        add(0,0,0, 1,1,1,0,0); add(0,0,0, 1,1,1,0,0); add(0,0,0, 2,1,1,0,0);
        add(0,1,1, 3,1,1,0,0); add(0,0,0, 3,1,1,0,0); add(0,0,0, 1,1,1,0,1);
        add(0,0,0, 1,1,1,0,0); add(0,0,0, 1,1,1,0,0); add(0,0,0, 2,1,1,0,0);

        // Reset held with iVS toggling, released while iVS is high.
        repeat (6) begin
            @(posedge clk); #1 bus.iVS = ~bus.iVS;
            @(negedge clk);
            chk("rst_hold_tick", int'(bus.frame_tick), 0);
        end
        bus.iVS = 1'b1;
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rel_no_tick", int'(bus.frame_tick), 0);
        end
        check_reset_values("rst");

        foreach (tbl[i]) begin
            do_frame(tbl[i].s, tbl[i].ml, tbl[i].mr, 2);
            chk("tbl_state", int'(bus.state_o), tbl[i].st);
            chk("tbl_sl", int'(bus.score_l), tbl[i].sl);
            chk("tbl_sr", int'(bus.score_r), tbl[i].sr);
            chk("tbl_dir", int'(bus.serve_dir), tbl[i].dir);
        end

        // miss_l pulsed between ticks while playing must be ignored.
        @(posedge clk); #1 bus.iVS = 1'b0; bus.miss_l = 1'b1;
        @(posedge clk); #1 bus.miss_l = 1'b0;
        do_frame(0, 0, 0, 2);
        chk("offtick_sr", int'(bus.score_r), 1);
        chk("offtick_state", int'(bus.state_o), 2);

        // Left wins with start held high throughout.
        guard = 0;
        while (m_state != 4 && guard < 80) begin
            do_frame(1, 0, (m_state == 2) ? 1 : 0, 1);
            guard++;
        end
        chk("win_state", int'(bus.state_o), 4);
        chk("win_over", int'(bus.game_over), 1);
        chk("win_sl", int'(bus.score_l), WIN);
        repeat (2) begin
            do_frame(1, 0, 0, 1);
            chk("held_start_no_restart", int'(bus.state_o), 4);
        end
        do_frame(0, 0, 0, 1);
        chk("release_still_over", int'(bus.state_o), 4);
        do_frame(1, 0, 0, 1);
        chk("restart_idle", int'(bus.state_o), 0);
        chk("restart_over_clr", int'(bus.game_over), 0);
        do_frame(1, 0, 0, 1);
        chk("newgame_state", int'(bus.state_o), 1);
        chk("newgame_sl", int'(bus.score_l), 0);

        // Random frames against the model.
        for (int i = 0; i < 300; i++) begin
            s  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            ml = ($urandom_range(0, 2) == 0) ? 1 : 0;
            mr = ($urandom_range(0, 2) == 0) ? 1 : 0;
            do_frame(s, ml, mr, int'($urandom_range(1, 4)));
        end

        // Reach PLAY, then reset mid-match.
        guard = 0;
        while (m_state != 2 && guard < 40) begin
            do_frame(guard % 2, 0, 0, 1);
            guard++;
        end
        chk("pre_reset_play", int'(bus.state_o), 2);
        @(posedge clk); #3 rst_n = 1'b0;
        #1 check_reset_values("midrst");
        bus.iVS = 1'b1;
        @(posedge clk); #3 rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("midrst_no_tick", int'(bus.frame_tick), 0);
        do_frame(1, 0, 0, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pong_game_sequencer.md
# pong_game_sequencer

Frame-rate game-flow controller for the Pong VGA design. It sits between the video sync generator and the game physics/render logic. It turns the vertical-sync rising edge into a one-cycle frame tick and runs the match state machine: attract, serve countdown, play, point pause, and game over. It owns both score registers and tells the physics datapath when to advance, when to re-centre the ball, and which way to serve.

## Interface
Parameters:
- WIN_SCORE, 5: score that ends the match; legal range 1–15.
- SERVE_FRAMES, 60: frame ticks spent in SERVE before play starts; legal range 1–255.
- POINT_FRAMES, 30: frame ticks spent in POINT after a miss; legal range 1–255.

Ports:
- iVGA_CLK, input, 1: pixel clock; the only clock.
- iRST_n, input, 1: reset, asynchronous, active-low.
- iVS, input, 1: vertical sync from the sync generator. A frame boundary is its 0→1 transition.
- start_in, input, 1: start/restart request (OR of player buttons), level.
- miss_l, input, 1: ball has left the field on the left side (right player scores). Level, sampled only on frame_tick.
- miss_r, input, 1: ball has left the field on the right side (left player scores). Level, sampled only on frame_tick.
- frame_tick, output, 1: one-cycle pulse per frame.
- state_o, output, 3: current state (IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4).
- physics_en, output, 1: physics may advance on frame_tick.
- ball_reset, output, 1: one-cycle pulse that re-centres ball and paddles.
- serve_dir, output, 1: serve direction; 1 = toward right, 0 = toward left.
- score_l, output, 4: left player score.
- score_r, output, 4: right player score.
- game_over, output, 1: match finished.

## Operation
- Edge detect:
  - vs_q <= iVS every cycle.
  - frame_tick <= iVS & ~vs_q.
  - vs_q resets to 1, so a high iVS at reset release does not produce a tick.
- All state transitions, counter updates and input sampling (start_in, miss_l, miss_r) happen only in cycles where frame_tick=1. Outside those cycles, state and counters hold.
- 8-bit frame counter cnt: loaded on entry to SERVE or POINT, decremented each tick.
- Start arming flag `armed`:
  - Cleared on entry to OVER.
  - Set on any tick with start_in=0.
  - In OVER, start_in is honoured only when armed=1, which forces a release before restart.
- IDLE:
  - On a tick with start_in=1: score_l and score_r go to 0, serve_dir goes to 1, cnt goes to SERVE_FRAMES, ball_reset pulses, next state is SERVE.
- SERVE:
  - Each tick decrements cnt.
  - On the tick where cnt==1, next state is PLAY.
- PLAY:
  - physics_en=1.
  - Tick with miss_l=1 and miss_r=0: score_r+1, serve_dir goes to 0.
  - Tick with miss_r=1 and miss_l=0: score_l+1, serve_dir goes to 1.
  - Tick with both set: no score change, serve_dir unchanged.
  - Any miss: cnt goes to POINT_FRAMES, next state is POINT.
- POINT:
  - Each tick decrements cnt.
  - On the tick where cnt==1:
    - If score_l>=WIN_SCORE or score_r>=WIN_SCORE, next state is OVER.
    - Otherwise ball_reset pulses, cnt goes to SERVE_FRAMES, next state is SERVE.
- OVER:
  - game_over=1; scores are frozen.
  - On a tick with start_in=1 and armed=1: next state is IDLE.
- Scores saturate at 15; increments beyond 15 are dropped.
- State encodings 5–7 are illegal and recover to IDLE on the next tick.

## Timing
- Reset values (asynchronous): state_o=0 (IDLE), frame_tick=0, physics_en=0, ball_reset=0, serve_dir=1, score_l=0, score_r=0, game_over=0, cnt=0, armed=0, vs_q=1.
- Reset asserted mid-match clears everything immediately, with no completion of the current frame.
- frame_tick goes high in the cycle after the first clock edge that samples iVS=1 following a sample of 0. It stays high exactly one cycle.
- All outputs are registered.
- state_o, scores, serve_dir, physics_en and game_over change on the clock edge that ends the frame_tick cycle.
- ball_reset is high for exactly the first cycle of the new state. It does not pulse on PLAY→POINT or OVER→IDLE.
- physics_en and game_over are decoded from the next state, so they align with state_o.
- Timing counts from the IDLE start tick:
  - The SERVE→PLAY transition occurs on the SERVE_FRAMES-th tick after entering SERVE.
  - A point pause lasts POINT_FRAMES ticks.

## Test plan
- Reset and attract: hold iRST_n=0 with iVS toggling, then release. Required: all outputs at reset values, no frame_tick on the first cycle even if iVS=1. Three vsync pulses with start_in=0 give three one-cycle ticks while state stays 0.
- Start and serve: SERVE_FRAMES=3; a tick with start_in=1 in IDLE. Required: state 1 plus a one-cycle ball_reset. After the 3rd subsequent tick, state is 2 and physics_en=1.
- Scoring: in PLAY, hold miss_r=1 over one tick. Required: score_l=1, serve_dir=1, state 3. After POINT_FRAMES ticks, state is 1 with a ball_reset pulse. Repeat with miss_l, giving score_r=1 and serve_dir=0.
- Simultaneous miss: miss_l=miss_r=1 on one tick. Required: scores unchanged, state goes to POINT.
- Win and restart: drive left to 5 points. Required: after the POINT pause, state is 4 and game_over=1. With start_in held high from before OVER, no restart occurs. After start_in=0 for one tick and then 1, state returns to 0 and the next start clears the scores.
- Misses outside ticks: pulse miss_l for one non-tick cycle in PLAY. Required: no score change.
